// File: rtl/rv32i_types.sv
// Shared RV32I decode types.
// Load/store funct3 encodings used by the memory stage.
package rv32i_types;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

endpackage

// File: rtl/load_formatter.sv
// Load data formatter: selects the addressed byte/half
// of a memory word and sign- or zero-extends it.
module load_formatter
  import rv32i_types::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = rdata[{off, 3'b000} +: 8];
  assign h = off[1] ? rdata[31:16] : rdata[15:0];

  // Extend the selected lane according to the load type
  always_comb begin
    result = rdata;
    case (funct3)
      LB:      result = {{24{b[7]}}, b};
      LBU:     result = {24'b0, b};
      LH:      result = {{16{h[15]}}, h};
      LHU:     result = {16'b0, h};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: registers one aligned
// data-memory request, stalls until the response arrives.
module mem_access_unit
  import rv32i_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exmem_valid,
  input  logic              exmem_load,
  input  logic              exmem_store,
  input  logic [2:0]        exmem_funct3,
  input  logic [ADDR_W-1:0] exmem_alu_out,
  input  logic [DATA_W-1:0] exmem_rs2_out,
  output logic [ADDR_W-1:0] dmem_address,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [3:0]        dmem_mbe,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_resp,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_stall,
  output logic              mem_exception
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic              op_present;
  logic              bad;
  logic              accept;
  logic [1:0]        off;
  logic [DATA_W-1:0] st_wdata;
  logic [3:0]        st_mbe;
  logic [DATA_W-1:0] fmt;
  logic              ld_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;

  assign off        = exmem_alu_out[1:0];
  assign op_present = exmem_valid & (exmem_load | exmem_store);
  assign accept     = (state == IDLE) & op_present & ~bad;

  assign mem_exception = (state == IDLE) & op_present & bad;
  assign mem_stall     = accept | (state == BUSY);

  // Flag conflicting, unknown-funct3 or misaligned accesses
  always_comb begin
    bad = 1'b0;
    if (exmem_load && exmem_store) begin
      bad = 1'b1;
    end else if (exmem_load) begin
      case (exmem_funct3)
        LB, LBU:  bad = 1'b0;
        LH, LHU:  bad = off[0];
        LW:       bad = |off;
        default:  bad = 1'b1;
      endcase
    end else begin
      case (exmem_funct3)
        SB:      bad = 1'b0;
        SH:      bad = off[0];
        SW:      bad = |off;
        default: bad = 1'b1;
      endcase
    end
  end

  // Replicate store data across lanes and pick byte enables
  always_comb begin
    st_wdata = exmem_rs2_out;
    st_mbe   = 4'b1111;
    case (exmem_funct3)
      SB: begin
        st_wdata = {4{exmem_rs2_out[7:0]}};
        st_mbe   = 4'b0001 << off;
      end
      SH: begin
        st_wdata = {2{exmem_rs2_out[15:0]}};
        st_mbe   = 4'b0011 << off;
      end
      default: ;
    endcase
  end

  load_formatter u_fmt (
    .rdata  (dmem_rdata),
    .funct3 (f3_q),
    .off    (off_q),
    .result (fmt)
  );

  // Request FSM: accept in IDLE, hold in BUSY, release in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      dmem_address <= '0;
      dmem_read    <= 1'b0;
      dmem_write   <= 1'b0;
      dmem_wdata   <= '0;
      dmem_mbe     <= 4'b0000;
      mem_rdata    <= '0;
      ld_q         <= 1'b0;
      f3_q         <= 3'b000;
      off_q        <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dmem_address <= {exmem_alu_out[ADDR_W-1:2], 2'b00};
            ld_q         <= exmem_load;
            f3_q         <= exmem_funct3;
            off_q        <= off;
            dmem_read    <= exmem_load;
            dmem_write   <= exmem_store;
            dmem_wdata   <= exmem_load ? '0 : st_wdata;
            dmem_mbe     <= exmem_load ? 4'b1111 : st_mbe;
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (dmem_resp) begin
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            mem_rdata  <= ld_q ? fmt : '0;
            state      <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table, hand-written
// sequences and random ops against a behavioural model.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        exmem_valid;
  logic        exmem_load;
  logic        exmem_store;
  logic [2:0]  exmem_funct3;
  logic [31:0] exmem_alu_out;
  logic [31:0] exmem_rs2_out;
  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        mem_exception;

  int checks = 0;
  int errors = 0;

  mem_access_unit dut (
    .clk           (clk),
    .rst           (rst),
    .exmem_valid   (exmem_valid),
    .exmem_load    (exmem_load),
    .exmem_store   (exmem_store),
    .exmem_funct3  (exmem_funct3),
    .exmem_alu_out (exmem_alu_out),
    .exmem_rs2_out (exmem_rs2_out),
    .dmem_address  (dmem_address),
    .dmem_read     (dmem_read),
    .dmem_write    (dmem_write),
    .dmem_wdata    (dmem_wdata),
    .dmem_mbe      (dmem_mbe),
    .dmem_rdata    (dmem_rdata),
    .dmem_resp     (dmem_resp),
    .mem_rdata     (mem_rdata),
    .mem_stall     (mem_stall),
    .mem_exception (mem_exception)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        exc;
    logic        acc_stall;
    logic        acc_rw;
    logic        after_rw;
    int          stall_cycles;
    int          read_cycles;
    int          write_cycles;
    logic        stable;
    logic        overlap;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mbe;
    logic        done_stall;
    logic        done_rw;
    logic [31:0] done_rdata;
  } obs_t;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          wt;
    logic        e_exc;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_mbe;
    logic [31:0] e_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    logic [1:0] s;
    s = f3[1:0];
    return 1 << s;
  endfunction

  function automatic logic model_bad(input logic ld, input logic st,
                                     input logic [2:0] f3,
                                     input logic [31:0] a);
    int unsigned sz;
    if (ld && st) return 1'b1;
    if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    if (!ld && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
    sz = size_of(f3);
    return (a % sz) != 0;
  endfunction

  function automatic void model_store(input logic [31:0] rs2,
                                      input logic [2:0] f3,
                                      input int off,
                                      output logic [31:0] wd,
                                      output logic [3:0] mbe);
    int sz;
    sz = size_of(f3);
    wd = '0;
    mbe = '0;
    for (int i = 0; i < 4; i++) begin
      wd[8*i +: 8] = rs2[8*(i % sz) +: 8];
      mbe[i] = (i >= off) && (i < off + sz);
    end
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rd,
                                             input logic [2:0] f3,
                                             input int off);
    int sz;
    logic [31:0] v;
    logic [31:0] mask;
    sz = size_of(f3);
    v = rd >> (8 * off);
    if (sz < 4) begin
      mask = (32'd1 << (8 * sz)) - 32'd1;
      v = v & mask;
      if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // Present one op at a negedge, answer after wt wait cycles.
  task automatic run_op(input logic ld, input logic st,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rd,
                        input int wt, output obs_t o);
    o = '{default: '0};
    o.stable = 1'b1;
    exmem_valid = 1'b1;
    exmem_load = ld;
    exmem_store = st;
    exmem_funct3 = f3;
    exmem_alu_out = a;
    exmem_rs2_out = d;
    dmem_rdata = rd;
    dmem_resp = 1'b0;
    #1;
    o.exc = mem_exception;
    o.acc_stall = mem_stall;
    o.acc_rw = dmem_read | dmem_write;
    @(negedge clk);
    if (!o.acc_stall) begin
      o.after_rw = dmem_read | dmem_write;
      exmem_valid = 1'b0;
      return;
    end
    o.stall_cycles = 1;
    for (int k = 0; k <= wt; k++) begin
      if (k == 0) begin
        o.addr = dmem_address;
        o.wdata = dmem_wdata;
        o.mbe = dmem_mbe;
      end else if (dmem_address !== o.addr || dmem_wdata !== o.wdata ||
                   dmem_mbe !== o.mbe) begin
        o.stable = 1'b0;
      end
      if (dmem_read) o.read_cycles++;
      if (dmem_write) o.write_cycles++;
      if (dmem_read && dmem_write) o.overlap = 1'b1;
      dmem_resp = (k == wt);
      #1;
      if (mem_stall) o.stall_cycles++;
      @(negedge clk);
    end
    dmem_resp = 1'b0;
    #1;
    o.done_stall = mem_stall;
    o.done_rw = dmem_read | dmem_write;
    o.done_rdata = mem_rdata;
    @(negedge clk);
    exmem_valid = 1'b0;
  endtask

  task automatic check_op(input string n, input logic ld, input int wt,
                          input logic e_exc, input logic [31:0] e_addr,
                          input logic [31:0] e_wdata, input logic [3:0] e_mbe,
                          input logic [31:0] e_rdata, input obs_t o);
    chk({n, ".exc"}, 32'(o.exc), 32'(e_exc));
    if (e_exc) begin
      chk({n, ".stall"}, 32'(o.acc_stall), 32'd0);
      chk({n, ".noreq"}, 32'(o.after_rw), 32'd0);
    end else begin
      chk({n, ".stall"}, 32'(o.acc_stall), 32'd1);
      chk({n, ".early"}, 32'(o.acc_rw), 32'd0);
      chk({n, ".addr"}, o.addr, e_addr);
      chk({n, ".mbe"}, 32'(o.mbe), 32'(e_mbe));
      if (!ld) chk({n, ".wdata"}, o.wdata, e_wdata);
      chk({n, ".rdcyc"}, o.read_cycles, ld ? wt + 1 : 0);
      chk({n, ".wrcyc"}, o.write_cycles, ld ? 0 : wt + 1);
      chk({n, ".stallcyc"}, o.stall_cycles, wt + 2);
      chk({n, ".stable"}, 32'(o.stable), 32'd1);
      chk({n, ".overlap"}, 32'(o.overlap), 32'd0);
      chk({n, ".donestall"}, 32'(o.done_stall), 32'd0);
      chk({n, ".donerw"}, 32'(o.done_rw), 32'd0);
      chk({n, ".rdata"}, o.done_rdata, e_rdata);
    end
  endtask

  vec_t vecs[13];
  obs_t o;

  initial begin
    logic        ld, st, bad;
    logic [2:0]  f3;
    logic [31:0] a, d, rd, ewd, erd;
    logic [3:0]  embe;
    int          wt;

    rst = 1'b1;
    exmem_valid = 1'b0;
    exmem_load = 1'b0;
    exmem_store = 1'b0;
    exmem_funct3 = 3'b000;
    exmem_alu_out = '0;
    exmem_rs2_out = '0;
    dmem_rdata = '0;
    dmem_resp = 1'b0;

    vecs[0]  = '{1, 0, 3'b010, 32'h1004, 32'h0, 32'hDEADBEEF, 2,
                 0, 32'h1004, 32'h0, 4'hF, 32'hDEADBEEF};
    vecs[1]  = '{1, 0, 3'b000, 32'h1003, 32'h0, 32'h80FF0000, 0,
                 0, 32'h1000, 32'h0, 4'hF, 32'hFFFFFF80};
    vecs[2]  = '{1, 0, 3'b100, 32'h1003, 32'h0, 32'h80FF0000, 1,
                 0, 32'h1000, 32'h0, 4'hF, 32'h00000080};
    vecs[3]  = '{1, 0, 3'b101, 32'h1002, 32'h0, 32'h80FF0000, 0,
                 0, 32'h1000, 32'h0, 4'hF, 32'h000080FF};
    vecs[4]  = '{0, 1, 3'b001, 32'h2002, 32'h1234ABCD, 32'hFFFFFFFF, 1,
                 0, 32'h2000, 32'hABCDABCD, 4'hC, 32'h0};
    vecs[5]  = '{1, 0, 3'b010, 32'h1001, 32'h0, 32'h0, 0,
                 1, 32'h0, 32'h0, 4'h0, 32'h0};
    vecs[6]  = '{0, 1, 3'b000, 32'h3001, 32'h00000055, 32'h0, 0,
                 0, 32'h3000, 32'h55555555, 4'h2, 32'h0};
    vecs[7]  = '{1, 0, 3'b001, 32'h1000, 32'h0, 32'h00008001, 3,
                 0, 32'h1000, 32'h0, 4'hF, 32'hFFFF8001};
    vecs[8]  = '{1, 0, 3'b011, 32'h1000, 32'h0, 32'h0, 0,
                 1, 32'h0, 32'h0, 4'h0, 32'h0};
    vecs[9]  = '{1, 1, 3'b010, 32'h1000, 32'h0, 32'h0, 0,
                 1, 32'h0, 32'h0, 4'h0, 32'h0};
    vecs[10] = '{0, 1, 3'b010, 32'h4000, 32'hCAFEF00D, 32'h0, 0,
                 0, 32'h4000, 32'hCAFEF00D, 4'hF, 32'h0};
    vecs[11] = '{0, 1, 3'b100, 32'h4000, 32'h0, 32'h0, 0,
                 1, 32'h0, 32'h0, 4'h0, 32'h0};
    vecs[12] = '{0, 1, 3'b001, 32'h2001, 32'h0, 32'h0, 0,
                 1, 32'h0, 32'h0, 4'h0, 32'h0};

    repeat (2) @(negedge clk);
    #1;
    chk("rst.read", 32'(dmem_read), 32'd0);
    chk("rst.write", 32'(dmem_write), 32'd0);
    chk("rst.addr", dmem_address, 32'd0);
    chk("rst.wdata", dmem_wdata, 32'd0);
    chk("rst.mbe", 32'(dmem_mbe), 32'd0);
    chk("rst.rdata", mem_rdata, 32'd0);
    chk("rst.stall", 32'(mem_stall), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].addr,
             vecs[i].rs2, vecs[i].rdata, vecs[i].wt, o);
      check_op($sformatf("vec%0d", i), vecs[i].ld, vecs[i].wt,
               vecs[i].e_exc, vecs[i].e_addr, vecs[i].e_wdata,
               vecs[i].e_mbe, vecs[i].e_rdata, o);
    end

    // Back-to-back sw then lw, each answered on the first BUSY cycle
    run_op(0, 1, 3'b010, 32'h6000, 32'h11223344, 32'h0, 0, o);
    check_op("b2b.sw", 0, 0, 0, 32'h6000, 32'h11223344, 4'hF, 32'h0, o);
    run_op(1, 0, 3'b010, 32'h6004, 32'h0, 32'hA5A5A5A5, 0, o);
    check_op("b2b.lw", 1, 0, 0, 32'h6004, 32'h0, 4'hF, 32'hA5A5A5A5, o);

    // Random ops against the model
    for (int n = 0; n < 150; n++) begin
      ld = $urandom_range(0, 1);
      st = ($urandom_range(0, 15) == 0) ? 1'b1 : ~ld;
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                       : (ld ? 3'($urandom_range(0, 2)) |
                                               {1'($urandom_range(0, 1)),
                                                2'b00}
                                             : 3'($urandom_range(0, 2)));
      if (ld && f3 == 3'b110) f3 = 3'b100;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = a[1:0] & ~2'(size_of(f3) - 1);
      d = $urandom;
      rd = $urandom;
      wt = $urandom_range(0, 3);
      bad = model_bad(ld, st, f3, a);
      ewd = '0;
      embe = 4'hF;
      erd = '0;
      if (!bad && st) model_store(d, f3, int'(a[1:0]), ewd, embe);
      if (!bad && ld) erd = model_load(rd, f3, int'(a[1:0]));
      run_op(ld, st, f3, a, d, rd, wt, o);
      check_op($sformatf("rnd%0d", n), ld, wt, bad,
               {a[31:2], 2'b00}, ewd, embe, erd, o);
    end

    // Reset in the middle of BUSY, then a stray response
    exmem_valid = 1'b1;
    exmem_load = 1'b1;
    exmem_store = 1'b0;
    exmem_funct3 = 3'b010;
    exmem_alu_out = 32'h5008;
    dmem_rdata = 32'h12345678;
    dmem_resp = 1'b0;
    @(negedge clk);
    #1;
    chk("mid.read", 32'(dmem_read), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid.rst.read", 32'(dmem_read), 32'd0);
    chk("mid.rst.addr", dmem_address, 32'd0);
    chk("mid.rst.mbe", 32'(dmem_mbe), 32'd0);
    chk("mid.rst.rdata", mem_rdata, 32'd0);
    exmem_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    dmem_resp = 1'b1;
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    chk("late.stall", 32'(mem_stall), 32'd0);
    chk("late.read", 32'(dmem_read), 32'd0);
    chk("late.rdata", mem_rdata, 32'd0);
    @(negedge clk);
    run_op(1, 0, 3'b000, 32'h7002, 32'h0, 32'h00810000, 1, o);
    check_op("recover", 1, 1, 0, 32'h7000, 32'h0, 4'hF, 32'hFFFFFF81, o);

    // Response pulse while idle must change nothing
    dmem_resp = 1'b1;
    dmem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    chk("idleresp.stall", 32'(mem_stall), 32'd0);
    chk("idleresp.rw", 32'(dmem_read | dmem_write), 32'd0);
    chk("idleresp.rdata", mem_rdata, 32'hFFFFFF81);
    @(negedge clk);
    run_op(0, 1, 3'b000, 32'h7003, 32'h000000AB, 32'h0, 0, o);
    check_op("after", 0, 0, 0, 32'h7000, 32'hABABABAB, 4'h8, 32'h0, o);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
